// File: rtl/pio_edge_master.sv
// pio_edge_master: Avalon-MM initiator that services an edge-capture PIO and emits sequence-numbered events.
// Define PIO_EDGE_MASTER_LEVEL_READ_EN to add the post-clear input-level read (RD_LVL/WAIT_LVL, evt_level).
module pio_edge_master #(
  parameter int unsigned       DATA_W        = 4,
  parameter logic [DATA_W-1:0] IRQ_MASK_INIT = '1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_irq,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_capture,
  output logic [DATA_W-1:0] evt_level,
  output logic [7:0]        evt_seq,
  output logic              busy
);

  typedef enum logic [2:0] {
    INIT_MASK,
    IDLE,
    RD_CAP,
    WAIT_CAP,
    CLR,
`ifdef PIO_EDGE_MASTER_LEVEL_READ_EN
    RD_LVL,
    WAIT_LVL,
`endif
    OUT
  } state_t;

  state_t            state, state_nx;
  logic              mask_done;
  logic [DATA_W-1:0] cap_q;
  logic [7:0]        seq_q;

  // Reset parks in IDLE so the bus is quiet under reset; mask_done then
  // forces exactly one INIT_MASK on the first clock after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask_done <= 1'b0;
      cap_q     <= '0;
      seq_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT_MASK) mask_done <= 1'b1;
      if (state == WAIT_CAP) cap_q <= avm_readdata;
      if (state == OUT && evt_ready) seq_q <= seq_q + 8'd1;
    end
  end

`ifdef PIO_EDGE_MASTER_LEVEL_READ_EN
  logic [DATA_W-1:0] level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else if (state == WAIT_LVL) begin
      level_q <= avm_readdata;
    end
  end

  assign evt_level = level_q;
`else
  assign evt_level = '0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      INIT_MASK: state_nx = IDLE;
      IDLE: begin
        if (!mask_done)   state_nx = INIT_MASK;
        else if (avm_irq) state_nx = RD_CAP;
      end
      RD_CAP:   state_nx = WAIT_CAP;
      WAIT_CAP: state_nx = (avm_readdata == '0) ? IDLE : CLR;
`ifdef PIO_EDGE_MASTER_LEVEL_READ_EN
      CLR:      state_nx = RD_LVL;
      RD_LVL:   state_nx = WAIT_LVL;
      WAIT_LVL: state_nx = OUT;
`else
      CLR:      state_nx = OUT;
`endif
      OUT:      if (evt_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Bus strobes are a pure decode of the state register and cap_q.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = '0;
    case (state)
      INIT_MASK: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 2'd2;
        avm_writedata  = IRQ_MASK_INIT;
      end
      RD_CAP: begin
        avm_chipselect = 1'b1;
        avm_address    = 2'd3;
      end
      CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 2'd3;
        avm_writedata  = cap_q;
      end
`ifdef PIO_EDGE_MASTER_LEVEL_READ_EN
      RD_LVL: begin
        avm_chipselect = 1'b1;
        avm_address    = 2'd0;
      end
`endif
      default: ;
    endcase
  end

  assign evt_valid   = (state == OUT);
  assign evt_capture = cap_q;
  assign evt_seq     = seq_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_pio_edge_master.sv
// Bench for pio_edge_master: behavioural edge-capture PIO slave plus an event scoreboard.
// Honours PIO_EDGE_MASTER_LEVEL_READ_EN for the level-read build.
`timescale 1ns/1ps
module tb_pio_edge_master;
`ifdef PIO_EDGE_MASTER_LEVEL_READ_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif
  localparam int LAT = LVL ? 6 : 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] avm_address;
  logic       avm_chipselect, avm_write_n;
  logic [3:0] avm_writedata, avm_readdata;
  logic       avm_irq;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [3:0] evt_capture, evt_level;
  logic [7:0] evt_seq;
  logic       busy;

  logic [3:0] in_port = 4'h0;
  logic [3:0] in_prev = 4'h0, cap_reg = 4'h0, mask_reg = 4'h0, rdata = 4'h0;
  logic       force_irq = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_seq = 8'h00;
  logic [6:0] bus_log[$];

  pio_edge_master #(.DATA_W(4), .IRQ_MASK_INIT(4'hF)) dut (
    .clk(clk), .reset(reset),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_irq(avm_irq),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_capture(evt_capture), .evt_level(evt_level),
    .evt_seq(evt_seq), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural PIO slave: rising-edge capture, any write to 3 clears, registered reads.
  assign avm_irq      = (|(cap_reg & mask_reg)) | force_irq;
  assign avm_readdata = rdata;

  always @(posedge clk) begin
    if (reset) begin
      in_prev  <= in_port;
      cap_reg  <= 4'h0;
      mask_reg <= 4'h0;
      rdata    <= 4'h0;
    end else begin
      in_prev <= in_port;
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) cap_reg <= 4'h0;
      else cap_reg <= cap_reg | (in_port & ~in_prev);
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask_reg <= avm_writedata;
      if (avm_chipselect && avm_write_n) begin
        case (avm_address)
          2'd0:    rdata <= in_port;
          2'd2:    rdata <= mask_reg;
          2'd3:    rdata <= cap_reg;
          default: rdata <= 4'h0;
        endcase
      end
    end
  end

  always @(negedge clk)
    if (!reset && avm_chipselect)
      bus_log.push_back({avm_address, avm_write_n, avm_write_n ? 4'h0 : avm_writedata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (evt_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", avm_chipselect); end
    checks++; if (avm_write_n !== 1'b1) begin errors++; $display("FAIL rst_wn: got %b want 1", avm_write_n); end
    checks++; if (avm_address !== 2'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", avm_address); end
    checks++; if (avm_writedata !== 4'h0) begin errors++; $display("FAIL rst_wd: got %h want 0", avm_writedata); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
    checks++; if (evt_capture !== 4'h0) begin errors++; $display("FAIL rst_cap: got %h want 0", evt_capture); end
    checks++; if (evt_level !== 4'h0) begin errors++; $display("FAIL rst_lvl: got %h want 0", evt_level); end
    checks++; if (evt_seq !== 8'h00) begin errors++; $display("FAIL rst_seq: got %h want 00", evt_seq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    tick();
    reset = 1'b0;
    bus_log.delete();
    @(negedge clk);
    checks++; if (avm_chipselect !== 1'b0) begin errors++; $display("FAIL init_pre_cs: got %b want 0", avm_chipselect); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b want 1", busy); end
    checks++; if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 2'd2, 4'hF}) begin
      errors++; $display("FAIL init_bus: got cs%b wn%b a%0d d%h want cs1 wn0 a2 dF", avm_chipselect, avm_write_n, avm_address, avm_writedata); end
    @(negedge clk);
    checks++; if ({busy, avm_chipselect} !== 2'b00) begin errors++; $display("FAIL init_idle: got busy%b cs%b want 00", busy, avm_chipselect); end
    repeat (4) @(negedge clk);
    checks++; if (bus_log.size() != 1) begin errors++; $display("FAIL init_count: got %0d accesses want 1", bus_log.size()); end
    checks++; if (mask_reg !== 4'hF) begin errors++; $display("FAIL init_mask: got %h want F", mask_reg); end
  endtask

  task automatic test_single_edge();
    int n; bit ok;
    logic [6:0] exp_log[$];
    in_port = 4'h0;
    repeat (3) tick();
    evt_ready = 1'b1;
    bus_log.delete();
    in_port = 4'b0100;
    wait_valid(20, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no evt_valid want valid within 20"); end
    checks++; if (n != LAT + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", n, LAT + 2); end
    checks++; if (evt_capture !== 4'b0100) begin errors++; $display("FAIL single_cap: got %b want 0100", evt_capture); end
    checks++; if (evt_level !== (LVL ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_lvl: got %b want %b", evt_level, LVL ? 4'b0100 : 4'b0000); end
    checks++; if (evt_seq !== exp_seq) begin errors++; $display("FAIL single_seq: got %h want %h", evt_seq, exp_seq); end
    checks++; if (avm_irq !== 1'b0) begin errors++; $display("FAIL single_irq: got %b want 0", avm_irq); end
    exp_log.push_back({2'd3, 1'b1, 4'h0});
    exp_log.push_back({2'd3, 1'b0, 4'b0100});
    if (LVL) exp_log.push_back({2'd0, 1'b1, 4'h0});
    checks++; if (bus_log.size() != exp_log.size()) begin errors++; $display("FAIL single_buslen: got %0d want %0d", bus_log.size(), exp_log.size()); end
    for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++) begin
      checks++; if (bus_log[i] !== exp_log[i]) begin errors++; $display("FAIL single_bus%0d: got %h want %h", i, bus_log[i], exp_log[i]); end
    end
    exp_seq++;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", evt_valid); end
    checks++; if (evt_seq !== exp_seq) begin errors++; $display("FAIL single_seqinc: got %h want %h", evt_seq, exp_seq); end
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n; bit ok;
    in_port = 4'h0;
    repeat (3) tick();
    evt_ready = 1'b0;
    in_port = 4'b1000;
    wait_valid(20, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout1: got no evt_valid want valid"); end
    checks++; if (evt_capture !== 4'b1000) begin errors++; $display("FAIL bp_cap1: got %b want 1000", evt_capture); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) in_port = 4'b1001;
      @(negedge clk);
      checks++; if ({evt_valid, evt_capture, evt_level, evt_seq} !== {1'b1, 4'b1000, LVL ? 4'b1000 : 4'b0000, exp_seq}) begin
        errors++; $display("FAIL bp_hold%0d: got v%b c%b l%b s%h want v1 c1000 l%b s%h", i, evt_valid, evt_capture, evt_level, evt_seq, LVL ? 4'b1000 : 4'b0000, exp_seq); end
    end
    tick();
    evt_ready = 1'b1;
    @(negedge clk);
    exp_seq++;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", evt_valid); end
    wait_valid(20, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout2: got no evt_valid want valid"); end
    checks++; if (evt_capture !== 4'b0001) begin errors++; $display("FAIL bp_cap2: got %b want 0001", evt_capture); end
    checks++; if (evt_level !== (LVL ? 4'b1001 : 4'b0000)) begin errors++; $display("FAIL bp_lvl2: got %b want %b", evt_level, LVL ? 4'b1001 : 4'b0000); end
    checks++; if (evt_seq !== exp_seq) begin errors++; $display("FAIL bp_seq2: got %h want %h", evt_seq, exp_seq); end
    exp_seq++;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drop2: got %b want 0", evt_valid); end
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_spurious();
    int valid_seen = 0;
    int writes = 0;
    repeat (3) tick();
    bus_log.delete();
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (evt_valid) valid_seen++;
    end
    foreach (bus_log[i]) if (bus_log[i][4] == 1'b0) writes++;
    checks++; if (writes != 0) begin errors++; $display("FAIL spur_write: got %0d writes want 0", writes); end
    checks++; if (bus_log.size() != 1) begin errors++; $display("FAIL spur_count: got %0d accesses want 1", bus_log.size()); end
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL spur_valid: got %0d valid cycles want 0", valid_seen); end
    checks++; if (evt_seq !== exp_seq) begin errors++; $display("FAIL spur_seq: got %h want %h", evt_seq, exp_seq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_busy: got %b want 0", busy); end
  endtask

  task automatic test_random_wrap();
    int n; bit ok;
    logic [3:0] pat;
    logic [3:0] want_lvl;
    bit wrap_seen = 1'b0;
    bit prev_ff = 1'b0;
    for (int k = 0; k < 260; k++) begin
      in_port = 4'h0;
      repeat (2) tick();
      pat = 4'($urandom_range(1, 15));
      want_lvl = LVL ? pat : 4'h0;
      in_port = pat;
      wait_valid(20, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout%0d: got no evt_valid want valid", k); end
      checks++; if ({evt_capture, evt_level, evt_seq} !== {pat, want_lvl, exp_seq}) begin
        errors++; $display("FAIL rnd_evt%0d: got c%b l%b s%h want c%b l%b s%h", k, evt_capture, evt_level, evt_seq, pat, want_lvl, exp_seq); end
      if (prev_ff && evt_seq == 8'h00) wrap_seen = 1'b1;
      prev_ff = (evt_seq == 8'hFF);
      repeat ($urandom_range(0, 3)) begin
        tick();
        @(negedge clk);
        checks++; if ({evt_valid, evt_capture} !== {1'b1, pat}) begin errors++; $display("FAIL rnd_hold%0d: got v%b c%b want v1 c%b", k, evt_valid, evt_capture, pat); end
      end
      tick();
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      exp_seq++;
    end
    checks++; if (!wrap_seen) begin errors++; $display("FAIL rnd_wrap: got no FF->00 transition want one"); end
  endtask

  task automatic test_mid_reset();
    int n; bit ok;
    bit found = 1'b0;
    in_port = 4'h0;
    repeat (2) tick();
    evt_ready = 1'b0;
    in_port = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL mrst_clr: got no CLR cycle want one"); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 2'd0, 4'h0}) begin
      errors++; $display("FAIL mrst_bus: got cs%b wn%b a%0d d%h want cs0 wn1 a0 d0", avm_chipselect, avm_write_n, avm_address, avm_writedata); end
    checks++; if ({evt_valid, evt_capture, evt_level, evt_seq, busy} !== {1'b0, 4'h0, 4'h0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL mrst_evt: got v%b c%h l%h s%h b%b want all zero", evt_valid, evt_capture, evt_level, evt_seq, busy); end
    exp_seq = 8'h00;
    tick();
    reset = 1'b0;
    bus_log.delete();
    repeat (5) @(negedge clk);
    checks++; if (bus_log.size() != 1) begin errors++; $display("FAIL mrst_init_count: got %0d want 1", bus_log.size()); end
    checks++; if (bus_log.size() > 0 && bus_log[0] !== {2'd2, 1'b0, 4'hF}) begin errors++; $display("FAIL mrst_init: got %h want %h", bus_log[0], {2'd2, 1'b0, 4'hF}); end
    in_port = 4'h0;
    repeat (2) tick();
    in_port = 4'b0100;
    wait_valid(20, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mrst_timeout: got no evt_valid want valid"); end
    checks++; if ({evt_capture, evt_seq} !== {4'b0100, exp_seq}) begin errors++; $display("FAIL mrst_evt2: got c%b s%h want c0100 s%h", evt_capture, evt_seq, exp_seq); end
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_backpressure();
    test_spurious();
    test_random_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
